// File: rtl/efuse_prog_sequencer.sv
// Programming sequencer for the 32-bit eFuse macro: powers the supply, fires one
// timed strobe per '1' bit (LSB first), then powers down and pulses done.
module efuse_prog_sequencer #(
    parameter int SETUP_CYC = 8,
    parameter int PULSE_CYC = 200,
    parameter int HOLD_CYC  = 8
) (
    input  logic        int_clock,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] prog_data,
    output logic        busy,
    output logic        done,
    output logic        efuse_pgm_en,
    output logic        efuse_csb,
    output logic [4:0]  efuse_addr,
    output logic        efuse_strobe,
    output logic [5:0]  prog_count
);

    typedef enum logic [2:0] {
        IDLE,
        PWR_UP,
        SCAN,
        ADDR,
        STRB,
        HOLD,
        PWR_DN,
        DONE
    } state_t;

    // The counter holds "cycles remaining minus one", so a state exits when it reads zero.
    localparam logic [15:0] SETUP_LOAD = 16'(SETUP_CYC - 1);
    localparam logic [15:0] PULSE_LOAD = 16'(PULSE_CYC - 1);
    localparam logic [15:0] HOLD_LOAD  = 16'(HOLD_CYC - 1);

    state_t      r_state;
    logic [31:0] r_data;
    logic [4:0]  r_index;
    logic [15:0] r_cnt;
    logic [5:0]  r_progCount;
    logic        r_busy;
    logic        r_done;
    logic        r_pgmEn;
    logic        r_csb;
    logic [4:0]  r_addr;
    logic        r_strobe;

    state_t      w_nextState;
    logic [4:0]  w_nextIndex;
    logic [15:0] w_loadVal;
    logic [15:0] w_nextCnt;
    logic        w_cntZero;
    logic        w_startAccept;

    assign w_cntZero     = (r_cnt == 16'd0);
    assign w_startAccept = (r_state == IDLE) && start;

    always_comb begin
        w_nextState = r_state;
        w_nextIndex = r_index;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = PWR_UP;
                    w_nextIndex = 5'd0;
                end
            end
            PWR_UP: begin
                if (w_cntZero) begin
                    w_nextState = SCAN;
                end
            end
            SCAN: begin
                if (r_data[r_index]) begin
                    w_nextState = ADDR;
                end else if (r_index == 5'd31) begin
                    w_nextState = PWR_DN;
                end else begin
                    w_nextIndex = r_index + 5'd1;
                end
            end
            ADDR: begin
                if (w_cntZero) begin
                    w_nextState = STRB;
                end
            end
            STRB: begin
                if (w_cntZero) begin
                    w_nextState = HOLD;
                end
            end
            HOLD: begin
                if (w_cntZero) begin
                    if (r_index == 5'd31) begin
                        w_nextState = PWR_DN;
                    end else begin
                        w_nextState = SCAN;
                        w_nextIndex = r_index + 5'd1;
                    end
                end
            end
            PWR_DN: begin
                if (w_cntZero) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Reload on every state change; otherwise count down and park at zero.
    always_comb begin
        w_loadVal = 16'd0;
        case (w_nextState)
            PWR_UP, ADDR: w_loadVal = SETUP_LOAD;
            STRB:         w_loadVal = PULSE_LOAD;
            HOLD, PWR_DN: w_loadVal = HOLD_LOAD;
            default:      w_loadVal = 16'd0;
        endcase
        if (w_nextState != r_state) begin
            w_nextCnt = w_loadVal;
        end else if (!w_cntZero) begin
            w_nextCnt = r_cnt - 16'd1;
        end else begin
            w_nextCnt = r_cnt;
        end
    end

    always_ff @(posedge int_clock) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_data      <= 32'd0;
            r_index     <= 5'd0;
            r_cnt       <= 16'd0;
            r_progCount <= 6'd0;
        end else begin
            r_state <= w_nextState;
            r_index <= w_nextIndex;
            r_cnt   <= w_nextCnt;
            if (w_startAccept) begin
                r_data      <= prog_data;
                r_progCount <= 6'd0;
            end else if ((w_nextState == STRB) && (r_state != STRB)) begin
                r_progCount <= r_progCount + 6'd1;
            end
        end
    end

    // Outputs are decoded from the next state so they are valid for every cycle of a state.
    always_ff @(posedge int_clock) begin
        if (!rst) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pgmEn  <= 1'b0;
            r_csb    <= 1'b1;
            r_addr   <= 5'd0;
            r_strobe <= 1'b0;
        end else begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pgmEn  <= 1'b0;
            r_csb    <= 1'b1;
            r_addr   <= 5'd0;
            r_strobe <= 1'b0;
            case (w_nextState)
                PWR_UP, SCAN: begin
                    r_busy  <= 1'b1;
                    r_pgmEn <= 1'b1;
                    r_csb   <= 1'b0;
                end
                ADDR, STRB, HOLD: begin
                    r_busy   <= 1'b1;
                    r_pgmEn  <= 1'b1;
                    r_csb    <= 1'b0;
                    r_addr   <= w_nextIndex;
                    r_strobe <= (w_nextState == STRB);
                end
                PWR_DN: begin
                    r_busy <= 1'b1;
                    r_csb  <= 1'b0;
                end
                DONE: begin
                    r_done <= 1'b1;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign efuse_pgm_en = r_pgmEn;
    assign efuse_csb    = r_csb;
    assign efuse_addr   = r_addr;
    assign efuse_strobe = r_strobe;
    assign prog_count   = r_progCount;

endmodule

// File: tb/tb_efuse_prog_sequencer.sv
// Directed bench for efuse_prog_sequencer: runs whole program sequences and compares
// busy length, strobe count/width/addresses and control levels against hand-computed values.
`timescale 1ns/1ps
module tb_efuse_prog_sequencer;

    localparam int SETUP = 8;
    localparam int PULSE = 200;
    localparam int HOLD  = 8;

    logic        intClock = 1'b0;
    logic        rst      = 1'b0;
    logic        start    = 1'b0;
    logic [31:0] progData = 32'd0;
    logic        busy;
    logic        done;
    logic        efusePgmEn;
    logic        efuseCsb;
    logic [4:0]  efuseAddr;
    logic        efuseStrobe;
    logic [5:0]  progCount;

    int checks = 0;
    int errors = 0;

    int       strbAddrs[$];
    int       obsBusyLen;
    int       obsStrobes;
    int       obsDoneLen;
    int       obsFirstRise;
    int       obsEnAfter;
    bit       obsWidthOk;
    bit       obsTimedOut;
    bit       obsExitBusy;
    logic [2:0] obsFirstCtl;

    efuse_prog_sequencer #(
        .SETUP_CYC(SETUP),
        .PULSE_CYC(PULSE),
        .HOLD_CYC (HOLD)
    ) dut (
        .int_clock   (intClock),
        .rst         (rst),
        .start       (start),
        .prog_data   (progData),
        .busy        (busy),
        .done        (done),
        .efuse_pgm_en(efusePgmEn),
        .efuse_csb   (efuseCsb),
        .efuse_addr  (efuseAddr),
        .efuse_strobe(efuseStrobe),
        .prog_count  (progCount)
    );

    always #12.5 intClock = ~intClock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Watches one sequence on falling edges until the cycle after done; start was set
    // high on the previous falling edge so the first sample is the first busy cycle.
    task automatic applyStimulus(input int budget, input bit keepStart, input int pulseAt,
                                 input logic [31:0] altData);
        int  cyc = 0;
        int  width = 0;
        int  riseAddr = 0;
        bit  prevStrobe = 1'b0;
        bit  seenDone = 1'b0;
        strbAddrs.delete();
        obsBusyLen   = 0;
        obsStrobes   = 0;
        obsDoneLen   = 0;
        obsFirstRise = -1;
        obsEnAfter   = 0;
        obsWidthOk   = 1'b1;
        obsTimedOut  = 1'b0;
        obsExitBusy  = 1'b0;
        obsFirstCtl  = 3'b000;
        while (1) begin
            @(negedge intClock);
            cyc++;
            if (cyc == 1) begin
                obsFirstCtl = {busy, efusePgmEn, efuseCsb};
                if (!keepStart) start = 1'b0;
            end
            if (cyc == pulseAt) begin
                start    = 1'b1;
                progData = altData;
            end
            if (pulseAt > 0 && cyc == pulseAt + 1) start = 1'b0;
            if (busy) obsBusyLen++;
            if (efuseStrobe) begin
                if (!prevStrobe) begin
                    obsStrobes++;
                    strbAddrs.push_back(int'(efuseAddr));
                    riseAddr = int'(efuseAddr);
                    width = 0;
                    if (obsFirstRise < 0) obsFirstRise = obsBusyLen;
                end else if (int'(efuseAddr) != riseAddr) begin
                    obsWidthOk = 1'b0;
                end
                width++;
            end else begin
                if (prevStrobe) begin
                    if (width != PULSE) obsWidthOk = 1'b0;
                    obsEnAfter = 0;
                end
                if (efusePgmEn) obsEnAfter++;
            end
            prevStrobe = efuseStrobe;
            if (done) begin
                obsDoneLen++;
                seenDone = 1'b1;
            end else if (seenDone) begin
                obsExitBusy = busy;
                break;
            end
            if (cyc >= budget) begin
                obsTimedOut = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int  waitCyc;
        bit  doneSeen;
        bit  busySeen;
        bit  addrOk;

        // Reset state
        repeat (3) @(negedge intClock);
        checkOutput("rstBusy",   busy,        1'b0);
        checkOutput("rstDone",   done,        1'b0);
        checkOutput("rstPgmEn",  efusePgmEn,  1'b0);
        checkOutput("rstCsb",    efuseCsb,    1'b1);
        checkOutput("rstAddr",   efuseAddr,   5'd0);
        checkOutput("rstStrobe", efuseStrobe, 1'b0);
        checkOutput("rstCount",  progCount,   6'd0);
        rst = 1'b1;
        @(negedge intClock);

        // Edge bits: fuses 0 and 31
        progData = 32'h8000_0001;
        start    = 1'b1;
        applyStimulus(2000, 1'b0, -1, 32'd0);
        checkOutput("edgeTimeout",  obsTimedOut, 1'b0);
        checkOutput("edgeFirstCtl", obsFirstCtl, 3'b110);
        checkOutput("edgeBusyLen",  obsBusyLen,  480);
        checkOutput("edgeStrobes",  obsStrobes,  2);
        checkOutput("edgeAddr0",    strbAddrs.size() > 0 ? strbAddrs[0] : -1, 0);
        checkOutput("edgeAddr1",    strbAddrs.size() > 1 ? strbAddrs[1] : -1, 31);
        checkOutput("edgeWidth",    obsWidthOk,  1'b1);
        checkOutput("edgeFirstRise", obsFirstRise, SETUP + 1 + SETUP + 1);
        checkOutput("edgeEnAfter",  obsEnAfter,  HOLD);
        checkOutput("edgeDoneLen",  obsDoneLen,  1);
        checkOutput("edgeCount",    progCount,   6'd2);

        // Zero word also proves prog_count is cleared on a new start
        @(negedge intClock);
        progData = 32'h0000_0000;
        start    = 1'b1;
        applyStimulus(500, 1'b0, -1, 32'd0);
        checkOutput("zeroTimeout", obsTimedOut, 1'b0);
        checkOutput("zeroBusyLen", obsBusyLen,  48);
        checkOutput("zeroStrobes", obsStrobes,  0);
        checkOutput("zeroDoneLen", obsDoneLen,  1);
        checkOutput("zeroCount",   progCount,   6'd0);
        checkOutput("zeroIdleCsb", efuseCsb,    1'b1);

        // Full word
        @(negedge intClock);
        progData = 32'hFFFF_FFFF;
        start    = 1'b1;
        applyStimulus(8000, 1'b0, -1, 32'd0);
        addrOk = (strbAddrs.size() == 32);
        for (int i = 0; i < strbAddrs.size(); i++) begin
            if (strbAddrs[i] != i) addrOk = 1'b0;
        end
        checkOutput("fullTimeout",   obsTimedOut,  1'b0);
        checkOutput("fullBusyLen",   obsBusyLen,   6960);
        checkOutput("fullStrobes",   obsStrobes,   32);
        checkOutput("fullAddrOrder", addrOk,       1'b1);
        checkOutput("fullWidth",     obsWidthOk,   1'b1);
        checkOutput("fullFirstRise", obsFirstRise, 18);
        checkOutput("fullEnAfter",   obsEnAfter,   HOLD);
        checkOutput("fullCount",     progCount,    6'd32);

        // Start pulsed mid-strobe with different data is ignored
        @(negedge intClock);
        progData = 32'h0000_0010;
        start    = 1'b1;
        applyStimulus(2000, 1'b0, 100, 32'hFFFF_FFFF);
        checkOutput("ignTimeout", obsTimedOut, 1'b0);
        checkOutput("ignBusyLen", obsBusyLen,  264);
        checkOutput("ignStrobes", obsStrobes,  1);
        checkOutput("ignAddr",    strbAddrs.size() > 0 ? strbAddrs[0] : -1, 4);
        checkOutput("ignCount",   progCount,   6'd1);
        busySeen = 1'b0;
        repeat (10) begin
            @(negedge intClock);
            if (busy) busySeen = 1'b1;
        end
        checkOutput("ignNoRerun", busySeen, 1'b0);

        // Reset at cycle 100 of a strobe
        progData = 32'h0000_0001;
        start    = 1'b1;
        @(negedge intClock);
        start   = 1'b0;
        waitCyc = 0;
        while (!efuseStrobe && waitCyc < 100) begin
            @(negedge intClock);
            waitCyc++;
        end
        checkOutput("mrStrobeSeen", efuseStrobe, 1'b1);
        repeat (99) @(negedge intClock);
        checkOutput("mrStillStrobe", efuseStrobe, 1'b1);
        rst = 1'b0;
        @(negedge intClock);
        checkOutput("mrStrobe", efuseStrobe, 1'b0);
        checkOutput("mrPgmEn",  efusePgmEn,  1'b0);
        checkOutput("mrCsb",    efuseCsb,    1'b1);
        checkOutput("mrBusy",   busy,        1'b0);
        checkOutput("mrAddr",   efuseAddr,   5'd0);
        checkOutput("mrCount",  progCount,   6'd0);
        rst = 1'b1;
        doneSeen = 1'b0;
        repeat (20) begin
            @(negedge intClock);
            if (done) doneSeen = 1'b1;
        end
        checkOutput("mrNoDone", doneSeen, 1'b0);
        start = 1'b1;
        applyStimulus(2000, 1'b0, -1, 32'd0);
        checkOutput("mrRerunTimeout", obsTimedOut, 1'b0);
        checkOutput("mrRerunBusyLen", obsBusyLen,  264);
        checkOutput("mrRerunCount",   progCount,   6'd1);

        // Back-to-back with start held high
        @(negedge intClock);
        progData = 32'h0000_0004;
        start    = 1'b1;
        applyStimulus(2000, 1'b1, -1, 32'd0);
        checkOutput("b2bTimeout1",   obsTimedOut,  1'b0);
        checkOutput("b2bBusyLen1",   obsBusyLen,   264);
        checkOutput("b2bAddr1",      strbAddrs.size() > 0 ? strbAddrs[0] : -1, 2);
        checkOutput("b2bFirstRise1", obsFirstRise, 20);
        checkOutput("b2bDoneLen1",   obsDoneLen,   1);
        checkOutput("b2bIdleGap",    obsExitBusy,  1'b0);
        applyStimulus(2000, 1'b0, -1, 32'd0);
        checkOutput("b2bFirstCtl2",  obsFirstCtl,  3'b110);
        checkOutput("b2bTimeout2",   obsTimedOut,  1'b0);
        checkOutput("b2bBusyLen2",   obsBusyLen,   264);
        checkOutput("b2bStrobes2",   obsStrobes,   1);
        checkOutput("b2bAddr2",      strbAddrs.size() > 0 ? strbAddrs[0] : -1, 2);
        checkOutput("b2bCount2",     progCount,    6'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
